// File: rtl/semiauto_cmd_pkg.sv
// Shared codes for the semi-auto direction-command front end: FSM state codes,
// enabled global modes, command bit positions and the press-priority encoder.
package semiauto_cmd_pkg;

  localparam logic [1:0] FSM_WAIT = 2'b00;
  localparam logic [1:0] FSM_MOVE = 2'b01;
  localparam logic [1:0] FSM_TURN = 2'b10;
  localparam logic [1:0] FSM_COOL = 2'b11;

  localparam logic [1:0] GS_SEMI_A = 2'b01;
  localparam logic [1:0] GS_SEMI_B = 2'b10;

  // Command vector bit positions, highest index wins a simultaneous press.
  localparam int CMD_W        = 4;
  localparam int CMD_STRAIGHT = 3;
  localparam int CMD_BACK     = 2;
  localparam int CMD_LEFT     = 1;
  localparam int CMD_RIGHT    = 0;

  typedef enum logic {
    CTRL_IDLE = 1'b0,
    CTRL_HELD = 1'b1
  } ctrl_state_e;

  function automatic logic gs_enabled(input logic [1:0] gs);
    return (gs == GS_SEMI_A) || (gs == GS_SEMI_B);
  endfunction

  function automatic logic [CMD_W-1:0] cmd_prio_pick(input logic [CMD_W-1:0] ev);
    logic [CMD_W-1:0] pick;
    pick = 4'b0000;
    if (ev[CMD_STRAIGHT]) begin
      pick[CMD_STRAIGHT] = 1'b1;
    end else if (ev[CMD_BACK]) begin
      pick[CMD_BACK] = 1'b1;
    end else if (ev[CMD_LEFT]) begin
      pick[CMD_LEFT] = 1'b1;
    end else if (ev[CMD_RIGHT]) begin
      pick[CMD_RIGHT] = 1'b1;
    end else begin
      pick = 4'b0000;
    end
    return pick;
  endfunction

endpackage

// File: rtl/semiauto_cmd_if.sv
// Button/mode inputs and held-command outputs between the driver side (master)
// and the command front end (slave).
interface semiauto_cmd_if;
  logic       power;
  logic [1:0] global_state;
  logic [1:0] fsm_state;
  logic       btn_straight;
  logic       btn_back;
  logic       btn_left;
  logic       btn_right;
  logic       straight;
  logic       back;
  logic       left;
  logic       right;
  logic       cmd_valid;

  modport master (
    output power, global_state, fsm_state,
    output btn_straight, btn_back, btn_left, btn_right,
    input  straight, back, left, right, cmd_valid
  );

  modport slave (
    input  power, global_state, fsm_state,
    input  btn_straight, btn_back, btn_left, btn_right,
    output straight, back, left, right, cmd_valid
  );
endinterface

// File: rtl/semiauto_cmd_btn_debounce.sv
// One button: 2-FF synchroniser, consecutive-mismatch debounce counter and a
// single-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = 21
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             level_d_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise, count mismatching cycles and flip the level on the last one.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
      cnt_r     <= '0;
    end else begin
      sync1_r   <= raw;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= ~level_r;
          cnt_r   <= '0;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign rise = level_r & ~level_d_r;

endmodule

// File: rtl/semiauto_cmd.sv
// Semi-auto direction-command front end: debounces four buttons and holds one
// one-hot command until the downstream FSM leaves its waiting state.
import semiauto_cmd_pkg::*;

module semiauto_cmd #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = 21
) (
  input  logic          sys_clk,
  input  logic          rst,
  semiauto_cmd_if.slave bus
);

  logic [CMD_W-1:0] btn_raw_s;
  logic [CMD_W-1:0] ev_s;
  logic [CMD_W-1:0] pick_s;
  logic             enable_s;
  ctrl_state_e      state_r;
  logic [CMD_W-1:0] cmd_r;
  logic             valid_r;

  assign btn_raw_s = {bus.btn_straight, bus.btn_back, bus.btn_left, bus.btn_right};

  for (genvar i = 0; i < CMD_W; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_btn_debounce (
      .sys_clk(sys_clk),
      .rst    (rst),
      .raw    (btn_raw_s[i]),
      .rise   (ev_s[i])
    );
  end

  // Block enable and winning press for this cycle.
  always_comb begin
    enable_s = bus.power & gs_enabled(bus.global_state);
    pick_s   = cmd_prio_pick(ev_s);
  end

  // IDLE/HELD controller; fsm_state is the downstream register, so a press on
  // the edge it leaves WAIT is dropped rather than queued.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r <= CTRL_IDLE;
      cmd_r   <= 4'b0000;
      valid_r <= 1'b0;
    end else if (!enable_s) begin
      state_r <= CTRL_IDLE;
      cmd_r   <= 4'b0000;
      valid_r <= 1'b0;
    end else if ((ev_s != 4'b0000) && (bus.fsm_state == FSM_WAIT)) begin
      state_r <= CTRL_HELD;
      cmd_r   <= pick_s;
      valid_r <= 1'b1;
    end else if ((state_r == CTRL_HELD) && (bus.fsm_state != FSM_WAIT)) begin
      state_r <= CTRL_IDLE;
      cmd_r   <= 4'b0000;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_r;
      cmd_r   <= cmd_r;
      valid_r <= valid_r;
    end
  end

  assign bus.straight  = cmd_r[CMD_STRAIGHT];
  assign bus.back      = cmd_r[CMD_BACK];
  assign bus.left      = cmd_r[CMD_LEFT];
  assign bus.right     = cmd_r[CMD_RIGHT];
  assign bus.cmd_valid = valid_r;

endmodule

// File: tb/tb_semiauto_cmd.sv
// Directed and random stimulus for semiauto_cmd, checked against a window-based
// behavioural model and explicit expected values.
module tb_semiauto_cmd;

  localparam int D = 4;

  localparam logic [4:0] V_IDLE = 5'b0_0000;
  localparam logic [4:0] V_S    = 5'b1_1000;
  localparam logic [4:0] V_B    = 5'b1_0100;
  localparam logic [4:0] V_L    = 5'b1_0010;
  localparam logic [4:0] V_R    = 5'b1_0001;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  int   total   = 0;
  int   bad     = 0;

  semiauto_cmd_if bus ();

  semiauto_cmd #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Model: per button, raw samples enter a 2-deep pipe; the debounced level
  // flips once the last D synchronised values all disagree with it.
  logic [3:0] m_p1, m_p2, m_lvl, m_rose, m_cmd;
  bit         m_win [4][$];

  task automatic model_edge();
    logic [3:0] raw, ev;
    bit all_diff;
    raw = {bus.btn_straight, bus.btn_back, bus.btn_left, bus.btn_right};
    if (rst) begin
      m_p1 = 4'b0000; m_p2 = 4'b0000; m_lvl = 4'b0000; m_rose = 4'b0000; m_cmd = 4'b0000;
      for (int b = 0; b < 4; b++) m_win[b].delete();
    end else begin
      ev = m_rose;
      for (int b = 0; b < 4; b++) begin
        m_win[b].push_back(m_p2[b]);
        if (m_win[b].size() > D) void'(m_win[b].pop_front());
        m_rose[b] = 1'b0;
        all_diff = (m_win[b].size() == D);
        foreach (m_win[b][j]) if (m_win[b][j] == m_lvl[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[b]  = ~m_lvl[b];
          m_rose[b] = m_lvl[b];
        end
      end
      m_p2 = m_p1;
      m_p1 = raw;
      if (!(bus.power && (bus.global_state == 2'b01 || bus.global_state == 2'b10))) begin
        m_cmd = 4'b0000;
      end else if (ev != 4'b0000 && bus.fsm_state == 2'b00) begin
        m_cmd = 4'b0000;
        for (int b = 3; b >= 0; b--) begin
          if (ev[b] && m_cmd == 4'b0000) m_cmd[b] = 1'b1;
        end
      end else if (bus.fsm_state != 2'b00) begin
        m_cmd = 4'b0000;
      end
    end
  endtask

  function automatic logic [4:0] observed();
    return {bus.cmd_valid, bus.straight, bus.back, bus.left, bus.right};
  endfunction

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = observed();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge sys_clk);
    #1;
    chk("model", {m_cmd != 4'b0000, m_cmd});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_btn(input logic [3:0] v);
    bus.btn_straight = v[3];
    bus.btn_back     = v[2];
    bus.btn_left     = v[1];
    bus.btn_right    = v[0];
  endtask

  initial begin
    bus.power = 1'b1; bus.global_state = 2'b01; bus.fsm_state = 2'b00;
    set_btn(4'b0000);
    rst = 1'b1;
    step();
    chk("reset", V_IDLE);
    rst = 1'b0;

    // Left press: asserts on the 7th edge after the raw rise, then holds.
    set_btn(4'b0010);
    steps(6);
    chk("left_early", V_IDLE);
    step();
    chk("left_latency", V_L);
    steps(20);
    chk("left_hold", V_L);
    set_btn(4'b0000);
    steps(8);
    chk("left_release", V_L);
    bus.fsm_state = 2'b01;
    step();
    chk("consume_move", V_IDLE);
    bus.fsm_state = 2'b00;

    // Bouncing right is rejected; a steady press is accepted.
    set_btn(4'b0001); step();
    set_btn(4'b0000); step();
    set_btn(4'b0001); step();
    set_btn(4'b0000); step();
    steps(10);
    chk("bounce_reject", V_IDLE);
    set_btn(4'b0001);
    steps(6);
    chk("right_early", V_IDLE);
    step();
    chk("right_latency", V_R);
    set_btn(4'b0000);
    steps(8);

    // Latest press replaces the held one; consumption; press while busy dropped.
    set_btn(4'b1000);
    steps(7);
    chk("straight_replace", V_S);
    set_btn(4'b0000);
    steps(8);
    bus.fsm_state = 2'b11;
    step();
    chk("consume_cool", V_IDLE);
    set_btn(4'b0100);
    steps(10);
    chk("press_while_busy", V_IDLE);
    set_btn(4'b0000);
    steps(8);
    bus.fsm_state = 2'b00;
    steps(4);
    chk("no_queued_event", V_IDLE);

    // Simultaneous press priority, then a later press while held.
    set_btn(4'b1010);
    steps(7);
    chk("priority_straight", V_S);
    set_btn(4'b1110);
    steps(7);
    chk("later_back", V_B);
    set_btn(4'b0000);
    steps(8);

    // Disable paths and re-enable with a button still held.
    set_btn(4'b0010);
    steps(7);
    chk("pre_power", V_L);
    bus.power = 1'b0;
    step();
    chk("power_off", V_IDLE);
    bus.power = 1'b1;
    steps(10);
    chk("reenable_held", V_IDLE);
    set_btn(4'b0000);
    steps(8);
    set_btn(4'b0010);
    steps(7);
    chk("repress", V_L);
    bus.global_state = 2'b00;
    step();
    chk("gs_off", V_IDLE);
    bus.global_state = 2'b10;
    set_btn(4'b0000);
    steps(8);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) set_btn(4'($urandom_range(0, 15)));
      bus.fsm_state = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.power = ($urandom_range(0, 39) != 0);
      bus.global_state = ($urandom_range(0, 29) == 0) ? 2'b00 :
                         (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
      step();
    end

    // Reset mid-debounce while held: full debounce needed afterwards.
    set_btn(4'b0000);
    bus.fsm_state = 2'b00; bus.power = 1'b1; bus.global_state = 2'b01;
    steps(8);
    set_btn(4'b0001);
    steps(7);
    chk("pre_reset_held", V_R);
    set_btn(4'b0000);
    steps(8);
    set_btn(4'b1000);
    steps(4);
    chk("mid_debounce", V_R);
    rst = 1'b1;
    step();
    chk("reset_held", V_IDLE);
    rst = 1'b0;
    steps(6);
    chk("post_reset_early", V_IDLE);
    step();
    chk("post_reset_full", V_S);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
